// File: rtl/trig_pipe_engine_if.sv
// Handshake and ROM bus for the trig pipe engine.
// The master side drives requests, accepts results and models the ROM.
interface trig_pipe_engine_if #(
    parameter int ANGLE_W = 12,
    parameter int OUT_W   = 10,
    parameter int LUT_AW  = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [ANGLE_W-1:0] angle;
    logic [1:0]         mode;
    logic [LUT_AW-1:0]  lut_addr;
    logic [OUT_W-1:0]   lut_q;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   sin_val;
    logic [OUT_W-1:0]   cos_val;
    logic               err;

    modport master (
        output in_valid, angle, mode, out_ready, lut_q,
        input  in_ready, lut_addr, out_valid, sin_val, cos_val, err
    );

    modport slave (
        input  in_valid, angle, mode, out_ready, lut_q,
        output in_ready, lut_addr, out_valid, sin_val, cos_val, err
    );
endinterface

// File: rtl/trig_pipe_engine.sv
// Handshaked sine/cosine engine: quadrant fold into a shared
// synchronous quarter-wave ROM, offset-binary results.
module trig_pipe_engine #(
    parameter int ANGLE_W    = 12,
    parameter int FULL_SCALE = 3600,
    parameter int OUT_W      = 10,
    parameter int LUT_AW     = 10
) (
    input logic                clk,
    input logic                rst_n,
    trig_pipe_engine_if.slave  bus
);
    localparam int AW1 = ANGLE_W + 1;
    localparam int QI  = FULL_SCALE / 4;
    localparam logic [AW1-1:0] Q1 = AW1'(QI);
    localparam logic [AW1-1:0] Q2 = AW1'(2 * QI);
    localparam logic [AW1-1:0] Q3 = AW1'(3 * QI);
    localparam logic [AW1-1:0] Q4 = AW1'(4 * QI);
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, WAIT1, CAP1, WAIT2, CAP2, HOLD
    } state_t;

    state_t            state;
    logic [1:0]        mode_r;
    logic              err_r;
    logic              s_neg;
    logic              c_neg;
    logic [LUT_AW-1:0] c_addr;

    logic [AW1-1:0] a;
    logic [AW1-1:0] s_f;
    logic [AW1-1:0] c_f;
    logic           s_n;
    logic           c_n;
    logic           bad;

    assign a   = {1'b0, bus.angle};
    assign bad = (a >= Q4);

    always_comb begin
        s_f = '0;
        c_f = '0;
        s_n = 1'b0;
        c_n = 1'b0;
        unique case (1'b1)
            (a < Q1): begin
                s_f = a;
                c_f = Q1 - a;
            end
            (a >= Q1 && a < Q2): begin
                s_f = Q2 - a;
                c_f = a - Q1;
                c_n = 1'b1;
            end
            (a >= Q2 && a < Q3): begin
                s_f = a - Q2;
                c_f = Q3 - a;
                s_n = 1'b1;
                c_n = 1'b1;
            end
            default: begin
                s_f = Q4 - a;
                c_f = a - Q3;
                s_n = 1'b1;
            end
        endcase
    end

    logic [OUT_W-1:0] s_q;
    logic [OUT_W-1:0] c_q;

    assign s_q = s_neg ? ~bus.lut_q : bus.lut_q;
    assign c_q = c_neg ? ~bus.lut_q : bus.lut_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_r        <= 2'b00;
            err_r         <= 1'b0;
            s_neg         <= 1'b0;
            c_neg         <= 1'b0;
            c_addr        <= '0;
            bus.lut_addr  <= '0;
            bus.sin_val   <= '0;
            bus.cos_val   <= '0;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_r       <= bus.mode;
                        err_r        <= bad;
                        bus.err      <= bad;
                        s_neg        <= s_n;
                        c_neg        <= c_n;
                        c_addr       <= LUT_AW'(c_f);
                        bus.in_ready <= 1'b0;
                        // An illegal angle leaves the ROM address untouched
                        if (!bad)
                            bus.lut_addr <= (bus.mode == 2'b01) ?
                                LUT_AW'(c_f) : LUT_AW'(s_f);
                        state <= WAIT1;
                    end
                end
                WAIT1: state <= CAP1;
                CAP1: begin
                    if (mode_r[1]) begin
                        bus.sin_val <= err_r ? MID : s_q;
                        if (!err_r)
                            bus.lut_addr <= c_addr;
                        state <= WAIT2;
                    end else if (mode_r == 2'b01) begin
                        bus.cos_val   <= err_r ? MID : c_q;
                        bus.sin_val   <= MID;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        bus.sin_val   <= err_r ? MID : s_q;
                        bus.cos_val   <= MID;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                WAIT2: state <= CAP2;
                CAP2: begin
                    bus.cos_val   <= err_r ? MID : c_q;
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/trig_pipe_engine.md
# trig_pipe_engine

Parametrised, handshaked sine/cosine engine. It is the next generation of the quadrant-folding trig block. It accepts an angle in fixed-point units of 1/(FULL_SCALE) turn and folds it into the first quadrant. It reads a shared external synchronous quarter-wave ROM and returns sine, cosine or both in offset-binary. It sits between angle producers (NCO/sweep logic) and consumers needing paced, back-pressured results, and it replaces the free-running combinational-address version.

## Interface
- `ANGLE_W`, default 12: angle input width.
- `FULL_SCALE`, default 3600: angle units per full turn. Must be divisible by 4 and satisfy FULL_SCALE ≤ 2^ANGLE_W.
- `OUT_W`, default 10: ROM data and output width (offset-binary).
- `LUT_AW`, default 10: ROM address width. Requires FULL_SCALE/4 < 2^LUT_AW.

Ports (clock and reset first):
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: engine can accept a request.
- `angle`  in  ANGLE_W: angle, legal range 0..FULL_SCALE-1.
- `mode`  in  2: 00 = sin, 01 = cos, 1x = both.
- `lut_addr`  out  LUT_AW: registered ROM address.
- `lut_q`  in  OUT_W: ROM data, valid one cycle after `lut_addr` changes.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `sin_val`  out  OUT_W: sine result.
- `cos_val`  out  OUT_W: cosine result.
- `err`  out  1: request angle was ≥ FULL_SCALE.

## Operation
- Q = FULL_SCALE/4. Quadrant: 0 for [0,Q), 1 for [Q,2Q), 2 for [2Q,3Q), 3 for [3Q,4Q).
- Sine address per quadrant: a, 2Q−a, a−2Q, 4Q−a. Sine is negated in quadrants 2 and 3.
- Cosine address per quadrant: Q−a, a−Q, 3Q−a, a−3Q. Cosine is negated in quadrants 1 and 2.
- Folding arithmetic is done at ANGLE_W+1 bits, then truncated to LUT_AW. Addresses span 0..Q inclusive, so the ROM depth is Q+1.
- Negation is the bitwise complement of `lut_q` (value' = 2^OUT_W−1−value).
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, register angle, mode and fold results; load `lut_addr` with the first address (sin, or cos if mode=01); go to WAIT1.
  - WAIT1: go to CAP1.
  - CAP1: capture `lut_q` (negated if required) into the first result. If mode is both, load the cos address and go to WAIT2; otherwise go to HOLD.
  - WAIT2: go to CAP2.
  - CAP2: capture cos, go to HOLD.
  - HOLD: `out_valid`=1, outputs stable. On `out_ready`, go to IDLE.
- Unselected output: forced to midscale 2^(OUT_W−1) at capture for single-function modes.
- Illegal angle (≥ FULL_SCALE): `err`=1, the ROM is not read, and `lut_addr` keeps its value. Both outputs are midscale. The request still takes the same state path and latency as its mode.
- Reset (async, any state): state=IDLE, `lut_addr`=0, `sin_val`=`cos_val`=0, `err`=0, `out_valid`=0. `in_ready`=1 once in IDLE. A request in flight is discarded.

## Timing
- Accept edge E0 → `out_valid` high after E2 (sin/cos) or after E4 (both).
- `in_ready` is high only in IDLE. There is no overlap of requests.
- `out_valid` with `out_ready` high in the same cycle transfers the result; the engine is back in IDLE next cycle.
- Minimum request spacing: 4 cycles for single mode, 6 cycles for both.
- `sin_val`, `cos_val` and `err` stay stable from `out_valid` rise until the transfer. `out_valid` never drops without `out_ready`.
- `in_valid` and `angle` outside IDLE are ignored and do not need to be held.

## Test plan
Bench ROM model: q = round(511·sin(addr·π/1800)) + 512, 1-cycle latency, FULL_SCALE=3600.
- angle=0, mode=both → sin_val=512, cos_val=1023, out_valid 4 cycles after accept, err=0.
- angle=2700, mode=both → sin addr 900, sin_val=0; cos addr 0, cos_val=512.
- angle=1800, mode=sin → sin_val=511 (complemented midscale), cos_val=512, latency 2 cycles.
- angle=900, mode=cos, out_ready held low 10 cycles → out_valid and values stable; in_ready=0 throughout; cos_val=511.
- angle=3600, mode=sin → err=1, sin_val=cos_val=512, lut_addr unchanged.
- rst_n pulsed low in WAIT2 → immediately out_valid=0, all outputs 0, in_ready=1 after release; the next request completes normally.
